vga_timing_gen: RTL and testbench

// Source end of the vga_if pixel stream. Generates hcount/vcount, hsync/vsync
// and hblnk/vblnk for an 800x600@60 Hz raster (40 MHz pixel rate) and feeds
// the head of the draw chain (background -> platforms -> figures).

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters, sync and blank decode,
// line/frame ticks and a completed-frame counter. Every output is a flop;
// flags are decoded from the next count so they line up with the count shown.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [11:0] hcount_o,
    output logic [11:0] vcount_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        hblnk_o,
    output logic        vblnk_o,
    output logic [11:0] rgb_o,
    output logic        frame_start_o,
    output logic        line_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(HT - 1);
    localparam logic [11:0] V_LAST   = 12'(VT - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    // The 12-bit counters must be able to hold the last count of each axis.
    generate
        if ((HT - 1) > 4095 || (VT - 1) > 4095) begin : g_range_chk
            $error("vga_timing_gen: raster totals exceed 12-bit counter range");
        end
    endgenerate

    logic [11:0] hcount_q, hcount_d;
    logic [11:0] vcount_q, vcount_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] rgb_q;

    // Next count, tick pulses and flags decoded from that next count.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblnk_d       = hblnk_q;
        vblnk_d       = vblnk_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en_i) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = 12'd0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 12'd0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    vcount_d = vcount_q + 12'd1;
                end
            end else begin
                hcount_d = hcount_q + 12'd1;
            end
            hblnk_d = (hcount_d >= H_ACT);
            vblnk_d = (vcount_d >= V_ACT);
            hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VS_POL : ~VS_POL;
        end else begin
            // Paused: everything holds and ticks stay low (set by defaults).
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // State register; reset wins over enable and drops any sync in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= 12'd0;
            vcount_q      <= 12'd0;
            frame_cnt_q   <= 16'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= 12'h000;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= 12'h000;
        end
    end

    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign hblnk_o       = hblnk_q;
    assign vblnk_o       = vblnk_q;
    assign rgb_o         = rgb_q;
    assign frame_start_o = frame_start_q;
    assign line_start_o  = line_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line-level
// timing and a shrunken raster (16x10) for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full 800x600 instance
    logic        rst_b, en_b;
    logic [11:0] b_hcount, b_vcount, b_rgb;
    logic        b_hsync, b_vsync, b_hblnk, b_vblnk, b_fs, b_ls;
    logic [15:0] b_fc;

    // Small raster: HT=16 (sync 10..12, blank>=8), VT=10 (sync 7..8, blank>=6)
    logic        rst_s, en_s;
    logic [11:0] s_hcount, s_vcount, s_rgb;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs, s_ls;
    logic [15:0] s_fc;

    vga_timing_gen dut_big (
        .clk(clk), .rst(rst_b), .en_i(en_b),
        .hcount_o(b_hcount), .vcount_o(b_vcount), .hsync_o(b_hsync), .vsync_o(b_vsync),
        .hblnk_o(b_hblnk), .vblnk_o(b_vblnk), .rgb_o(b_rgb),
        .frame_start_o(b_fs), .line_start_o(b_ls), .frame_cnt_o(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_sm (
        .clk(clk), .rst(rst_s), .en_i(en_s),
        .hcount_o(s_hcount), .vcount_o(s_vcount), .hsync_o(s_hsync), .vsync_o(s_vsync),
        .hblnk_o(s_hblnk), .vblnk_o(s_vblnk), .rgb_o(s_rgb),
        .frame_start_o(s_fs), .line_start_o(s_ls), .frame_cnt_o(s_fc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the small raster
    int          m_h, m_v;
    logic [15:0] m_fc;
    logic        m_ls, m_fs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_fc = 16'd0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step(input logic en);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (en) begin
            if (m_h == 15) begin
                m_h  = 0;
                m_ls = 1'b1;
                if (m_v == 9) begin
                    m_v  = 0;
                    m_fs = 1'b1;
                    m_fc = m_fc + 16'd1;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    task automatic check_sm(input string tag);
        check_eq({tag, ".h"},   32'(s_hcount), 32'(m_h));
        check_eq({tag, ".v"},   32'(s_vcount), 32'(m_v));
        check_eq({tag, ".hs"},  32'(s_hsync),  32'(m_h >= 10 && m_h <= 12));
        check_eq({tag, ".vs"},  32'(s_vsync),  32'(m_v >= 7 && m_v <= 8));
        check_eq({tag, ".hb"},  32'(s_hblnk),  32'(m_h >= 8));
        check_eq({tag, ".vb"},  32'(s_vblnk),  32'(m_v >= 6));
        check_eq({tag, ".ls"},  32'(s_ls),     32'(m_ls));
        check_eq({tag, ".fs"},  32'(s_fs),     32'(m_fs));
        check_eq({tag, ".fc"},  32'(s_fc),     32'(m_fc));
        check_eq({tag, ".rgb"}, 32'(s_rgb),    32'h0);
    endtask

    initial begin
        int first_fs;
        int n_en;
        int n_fs;
        int h;
        logic found;

        rst_b = 1'b1; en_b = 1'b1;
        rst_s = 1'b1; en_s = 1'b0;
        repeat (3) tick();

        // Reset state of the full-size instance
        check_eq("rst.h",   32'(b_hcount), 32'd0);
        check_eq("rst.v",   32'(b_vcount), 32'd0);
        check_eq("rst.hs",  32'(b_hsync),  32'd0);
        check_eq("rst.vs",  32'(b_vsync),  32'd0);
        check_eq("rst.hb",  32'(b_hblnk),  32'd0);
        check_eq("rst.vb",  32'(b_vblnk),  32'd0);
        check_eq("rst.fc",  32'(b_fc),     32'd0);
        check_eq("rst.ls",  32'(b_ls),     32'd0);
        check_eq("rst.fs",  32'(b_fs),     32'd0);
        check_eq("rst.rgb", 32'(b_rgb),    32'd0);
        model_reset();
        check_sm("rst_sm");

        // One full line at 800x600 timing: blank at 800, sync 840..967, wrap at 1055
        rst_b = 1'b0;
        for (int i = 1; i <= 1056; i++) begin
            tick();
            h = i % 1056;
            check_eq($sformatf("line%0d.h", i),  32'(b_hcount), 32'(h));
            check_eq($sformatf("line%0d.v", i),  32'(b_vcount), 32'(i / 1056));
            check_eq($sformatf("line%0d.hb", i), 32'(b_hblnk),  32'(h >= 800));
            check_eq($sformatf("line%0d.hs", i), 32'(b_hsync),  32'(h >= 840 && h <= 967));
            check_eq($sformatf("line%0d.ls", i), 32'(b_ls),     32'(h == 0));
            check_eq($sformatf("line%0d.fs", i), 32'(b_fs),     32'd0);
            check_eq($sformatf("line%0d.vb", i), 32'(b_vblnk),  32'd0);
            check_eq($sformatf("line%0d.vs", i), 32'(b_vsync),  32'd0);
        end

        // Pause: counts hold and the line tick drops
        en_b = 1'b0;
        repeat (2) begin
            tick();
            check_eq("hold.h",  32'(b_hcount), 32'd0);
            check_eq("hold.v",  32'(b_vcount), 32'd1);
            check_eq("hold.ls", 32'(b_ls),     32'd0);
        end

        // Small raster: two free-running frames, first frame_start on step 160
        rst_s = 1'b0; en_s = 1'b1;
        first_fs = -1;
        n_fs = 0;
        for (int i = 1; i <= 320; i++) begin
            tick();
            model_step(1'b1);
            check_sm("run");
            if (s_fs) begin
                n_fs++;
                if (first_fs < 0) first_fs = i;
            end
        end
        check_eq("first_fs_step", 32'(first_fs), 32'd160);
        n_en = 320;

        // Random enable: advance only on en=1, one frame tick per 160 en steps
        for (int i = 0; i < 1200; i++) begin
            en_s = 1'($urandom_range(0, 1));
            tick();
            model_step(en_s);
            check_sm("rand");
            if (en_s) n_en++;
            if (s_fs) n_fs++;
        end
        check_eq("fs_per_en_steps", 32'(n_fs), 32'(n_en / 160));

        // Preload frame_cnt to FFFF on an ordinary step away from the frame end
        en_s = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_v < 5 && m_h != 15) begin
                found = 1'b1;
                break;
            end
            tick();
            model_step(1'b1);
            check_sm("seek_pre");
        end
        check_eq("reach_preload", 32'(found), 32'd1);
        force dut_sm.frame_cnt_d = 16'hFFFF;
        tick();
        release dut_sm.frame_cnt_d;
        model_step(1'b1);
        m_fc = 16'hFFFF;
        check_sm("preload");
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            model_step(1'b1);
            check_sm("to_wrap");
            if (m_fs) begin
                check_eq("wrap.fc", 32'(s_fc), 32'h0000);
                check_eq("wrap.fs", 32'(s_fs), 32'd1);
                found = 1'b1;
                break;
            end
        end
        check_eq("reach_wrap", 32'(found), 32'd1);

        // Reset inside both sync pulses (h=11, v=7)
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_h == 11 && m_v == 7) begin
                found = 1'b1;
                break;
            end
            tick();
            model_step(1'b1);
            check_sm("seek_rst");
        end
        check_eq("reach_midrst", 32'(found), 32'd1);
        check_eq("pre_rst.hs", 32'(s_hsync), 32'd1);
        check_eq("pre_rst.vs", 32'(s_vsync), 32'd1);
        rst_s = 1'b1;
        tick();
        model_reset();
        check_sm("midrst");
        rst_s = 1'b0;
        tick();
        model_step(1'b1);
        check_sm("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
